// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM encoding, op codes
// and iteration constants.
// Optional feature macro: MULDIV_DIV_EN (divide path and divide-by-zero flag).
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic       OP_MUL      = 1'b0;
    localparam logic       OP_DIV      = 1'b1;
    localparam logic [3:0] ITER_COUNT  = 4'd8;
    localparam logic [7:0] DZ_QUOTIENT = 8'hFF;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// Iteration counter for the sequencer: cleared when an operation is accepted,
// advanced once per radix-2 step, terminal count after ITER_COUNT steps.
module muldiv_iter_cnt
    import muldiv_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [3:0] cnt_q, cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 4'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Count register with synchronous clear from clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == ITER_COUNT);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequential 8x8 unsigned multiplier with optional restoring divider.
// Optional feature macro: MULDIV_DIV_EN (divide path and dz flag).
//
// state  | meaning
// S_IDLE | waiting for start; results held
// S_ITER | one radix-2 step per clock until the counter hits terminal count
// S_DONE | results registered, one-cycle done pulse; start accepted here
//
// The 16-bit accumulator holds the running product for multiply, or
// {partial remainder, dividend/quotient} for divide.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] res_hi,
    output logic [7:0] res_lo,
    output logic       dz
);

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [7:0]  res_hi_q, res_hi_d;
    logic [7:0]  res_lo_q, res_lo_d;
    logic [15:0] step_acc, step_mcand;
    logic [7:0]  step_mplier;
    logic        cnt_clear, cnt_en, cnt_tc;

`ifdef MULDIV_DIV_EN
    logic        op_q, op_d;
    logic        dz_q, dz_d;
    logic [8:0]  trial;
`else
    logic        unused_op;
    assign unused_op = op;
`endif

    muldiv_iter_cnt u_iter_cnt (
        .clk     (clk),
        .clr     (clr),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tc_o    (cnt_tc)
    );

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        step_acc    = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
        step_mcand  = {mcand_q[14:0], 1'b0};
        step_mplier = {1'b0, mplier_q[7:1]};
`ifdef MULDIV_DIV_EN
        // Partial remainder shifted left with the next dividend bit, minus divisor.
        trial = acc_q[15:7] - {1'b0, mplier_q};
        if (op_q == OP_DIV) begin
            step_mcand  = mcand_q;
            step_mplier = mplier_q;
            if (trial[8]) begin
                step_acc = {acc_q[14:0], 1'b0};
            end else begin
                step_acc = {trial[7:0], acc_q[6:0], 1'b1};
            end
        end
`endif
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
`ifdef MULDIV_DIV_EN
        op_d      = op_q;
        dz_d      = dz_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d   = S_ITER;
                    cnt_clear = 1'b1;
                    acc_d     = 16'h0000;
                    mcand_d   = {8'h00, a};
                    mplier_d  = b;
`ifdef MULDIV_DIV_EN
                    op_d = op;
                    dz_d = 1'b0;
                    if (op == OP_DIV) begin
                        acc_d = {8'h00, a};
                    end
`endif
                end
            end
            S_ITER: begin
`ifdef MULDIV_DIV_EN
                // Zero divisor short-circuits after a single busy cycle.
                if (op_q == OP_DIV && mplier_q == 8'h00) begin
                    state_d  = S_DONE;
                    res_hi_d = acc_q[7:0];
                    res_lo_d = DZ_QUOTIENT;
                    dz_d     = 1'b1;
                end else
`endif
                if (cnt_tc) begin
                    state_d  = S_DONE;
                    res_hi_d = acc_q[15:8];
                    res_lo_d = acc_q[7:0];
                end else begin
                    cnt_en   = 1'b1;
                    acc_d    = step_acc;
                    mcand_d  = step_mcand;
                    mplier_d = step_mplier;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; clr clears everything and aborts.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            acc_q    <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            res_hi_q <= 8'h00;
            res_lo_q <= 8'h00;
`ifdef MULDIV_DIV_EN
            op_q     <= OP_MUL;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
`ifdef MULDIV_DIV_EN
            op_q     <= op_d;
            dz_q     <= dz_d;
`endif
        end
    end

    assign busy   = (state_q == S_ITER);
    assign done   = (state_q == S_DONE);
    assign res_hi = res_hi_q;
    assign res_lo = res_lo_q;
`ifdef MULDIV_DIV_EN
    assign dz     = dz_q;
`else
    assign dz     = 1'b0;
`endif

endmodule
